// File: rtl/guitar_pkg.sv
// Shared definitions for the note judging logic.
//   NUM_LANES     : number of note lanes (green, red, yellow, blue, orange)
//   LANE_KEY      : USB HID keycode assigned to each lane, index = lane
//   judge_state_t : judging FSM states
//   lane_sel_t    : result of decoding a keycode into a lane
//   key_lane()    : keycode -> {valid, lane}; valid=0 for non-lane keys
package guitar_pkg;

    localparam int NUM_LANES = 5;

    localparam logic [7:0] LANE_KEY [NUM_LANES] = '{8'h04, 8'h16, 8'h07, 8'h09, 8'h0A};

    typedef enum logic [1:0] {
        IDLE,
        JUDGE,
        SCAN
    } judge_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] lane;
    } lane_sel_t;

    function automatic lane_sel_t key_lane(input logic [7:0] kc);
        lane_sel_t r;
        r = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (kc == LANE_KEY[i]) begin
                r.valid = 1'b1;
                r.lane  = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the VGA vertical sync into the Clk domain and turns its rising
// edge into a single-cycle tick.
//   Clk       in  : system clock
//   Reset_n   in  : async active-low reset
//   frame_clk in  : VGA_VS, asynchronous to Clk
//   tick      out : 1-cycle pulse, high 3 cycles after the frame_clk rise
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sync1 <= frame_clk;
            sync2 <= sync1;
            sync3 <= sync2;
            // Registered edge detect keeps tick glitch-free for the FSM.
            tick  <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/note_hit_judge.sv
// Judges lane key presses against falling notes and scans for notes that
// slipped past the strike line once per frame.
//   Clk        in  : system clock
//   Reset_n    in  : async active-low reset
//   keycode    in  : USB HID keycode, 0 = no key
//   frame_clk  in  : VGA_VS (async), rising edge starts a per-frame scan
//   note_valid in  : per-lane note present
//   note_y     in  : per-lane note centre y
//   hit_pulse  out : 1-cycle pulse per lane, note struck in the window
//   miss_pulse out : 1-cycle pulse per lane, note passed unhit or bad press
//   score      out : saturating score
//   combo      out : saturating consecutive-hit count
//   busy       out : FSM is judging or scanning
module note_hit_judge
    import guitar_pkg::*;
#(
    parameter int HIT_Y      = 400,
    parameter int WINDOW     = 16,
    parameter int HIT_POINTS = 10,
    parameter int COMBO_MAX  = 99,
    parameter int SCORE_MAX  = 9999
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [7:0]                    keycode,
    input  logic                          frame_clk,
    input  logic [NUM_LANES-1:0]          note_valid,
    input  logic [NUM_LANES-1:0][9:0]     note_y,
    output logic [NUM_LANES-1:0]          hit_pulse,
    output logic [NUM_LANES-1:0]          miss_pulse,
    output logic [13:0]                   score,
    output logic [6:0]                    combo,
    output logic                          busy
);

    localparam logic signed [10:0] HIT_Y_S  = 11'(HIT_Y);
    localparam logic signed [10:0] WINDOW_S = 11'(WINDOW);
    localparam logic [9:0]         Y_HI     = 10'(HIT_Y + WINDOW);
    localparam logic [9:0]         Y_LO     = 10'(HIT_Y - WINDOW);

    judge_state_t         state;
    logic [2:0]           lane;
    logic [7:0]           kc_q;
    logic                 pend_v;
    logic [2:0]           pend_lane;
    logic                 tick_pend;
    logic [NUM_LANES-1:0] judged;

    logic                 tick;
    lane_sel_t            key_sel;
    logic                 press;
    logic [NUM_LANES-1:0] in_window;
    logic [NUM_LANES-1:0] past_line;
    logic [NUM_LANES-1:0] rearm;
    logic [14:0]          score_sum;
    logic [13:0]          score_next;
    logic [6:0]           combo_next;

    frame_tick_sync u_tick (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign busy = (state != IDLE);

    // A press is the first cycle a lane key appears; holding it does nothing.
    always_comb begin
        key_sel = key_lane(keycode);
        press   = key_sel.valid && (kc_q != keycode);
    end

    always_comb begin : lane_eval
        logic signed [10:0] dy;
        logic signed [10:0] ady;
        dy        = '0;
        ady       = '0;
        in_window = '0;
        past_line = '0;
        rearm     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            dy           = signed'({1'b0, note_y[i]}) - HIT_Y_S;
            ady          = dy[10] ? -dy : dy;
            in_window[i] = (ady <= WINDOW_S);
            past_line[i] = (note_y[i] > Y_HI);
            rearm[i]     = !note_valid[i] || (note_y[i] < Y_LO);
        end
    end

    // Hit reward includes the combo before this hit; 15-bit sum cannot wrap.
    always_comb begin
        score_sum  = 15'(score) + 15'(HIT_POINTS) + 15'(combo);
        score_next = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
        combo_next = (combo >= 7'(COMBO_MAX)) ? 7'(COMBO_MAX) : combo + 7'd1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            lane       <= '0;
            kc_q       <= '0;
            pend_v     <= 1'b0;
            pend_lane  <= '0;
            tick_pend  <= 1'b0;
            judged     <= '0;
            hit_pulse  <= '0;
            miss_pulse <= '0;
            score      <= '0;
            combo      <= '0;
        end else begin
            kc_q       <= keycode;
            hit_pulse  <= '0;
            miss_pulse <= '0;
            // Re-arm first; any set below is a later assignment and wins.
            judged     <= judged & ~rearm;

            // Single press slot: a newer press overwrites an unserved one.
            if (press) begin
                pend_v    <= 1'b1;
                pend_lane <= key_sel.lane;
            end else if (state == IDLE && pend_v) begin
                pend_v <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pend_v) begin
                        state <= JUDGE;
                        lane  <= pend_lane;
                        if (tick) tick_pend <= 1'b1;
                    end else if (tick || tick_pend) begin
                        state     <= SCAN;
                        lane      <= '0;
                        tick_pend <= 1'b0;
                    end
                end
                JUDGE: begin
                    if (note_valid[lane] && !judged[lane] && in_window[lane]) begin
                        hit_pulse[lane] <= 1'b1;
                        judged[lane]    <= 1'b1;
                        combo           <= combo_next;
                        score           <= score_next;
                    end else begin
                        miss_pulse[lane] <= 1'b1;
                        combo            <= '0;
                    end
                    if (tick || tick_pend) begin
                        state     <= SCAN;
                        lane      <= '0;
                        tick_pend <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    // Ticks arriving here are dropped; frames are far longer than a scan.
                    if (note_valid[lane] && !judged[lane] && past_line[lane]) begin
                        miss_pulse[lane] <= 1'b1;
                        judged[lane]     <= 1'b1;
                        combo            <= '0;
                    end
                    if (lane == 3'(NUM_LANES - 1)) begin
                        state <= IDLE;
                    end else begin
                        lane <= lane + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_hit_judge.sv
// Directed bench for note_hit_judge with a queue-based response checker.
module tb_note_hit_judge;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic [7:0]      keycode = '0;
    logic            frame_clk = 1'b0;
    logic [4:0]      note_valid = '0;
    logic [4:0][9:0] note_y = '0;
    logic [4:0]      hit_pulse;
    logic [4:0]      miss_pulse;
    logic [13:0]     score;
    logic [6:0]      combo;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [30:0] exp_q[$];
    int exp_score;
    int exp_combo;

    note_hit_judge dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .frame_clk  (frame_clk),
        .note_valid (note_valid),
        .note_y     (note_y),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .combo      (combo),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push_resp(input logic [4:0] hit, input logic [4:0] miss,
                             input int sc, input int cb);
        exp_q.push_back({hit, miss, 14'(sc), 7'(cb)});
    endtask

    // Model-based hit for the long saturation run.
    task automatic push_model_hit(input int l);
        exp_score = exp_score + 10 + exp_combo;
        if (exp_score > 9999) exp_score = 9999;
        exp_combo = (exp_combo >= 99) ? 99 : exp_combo + 1;
        push_resp(5'(1 << l), 5'b0, exp_score, exp_combo);
    endtask

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        logic [30:0] act;
        logic [30:0] exp;
        if (Reset_n && (hit_pulse != 5'b0 || miss_pulse != 5'b0)) begin
            act = {hit_pulse, miss_pulse, score, combo};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: hit=%b miss=%b score=%0d combo=%0d, required no pulse",
                         hit_pulse, miss_pulse, score, combo);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL response: hit=%b miss=%b score=%0d combo=%0d, required hit=%b miss=%b score=%0d combo=%0d",
                             act[30:26], act[25:21], act[20:7], act[6:0],
                             exp[30:26], exp[25:21], exp[20:7], exp[6:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic press(input logic [7:0] kc);
        @(posedge Clk); #1 keycode = kc;
        repeat (4) @(posedge Clk);
        #1 keycode = 8'h00;
        @(posedge Clk);
    endtask

    task automatic rearm(input int l);
        @(posedge Clk); #1 note_valid[l] = 1'b0;
        @(posedge Clk); #1 note_valid[l] = 1'b1;
    endtask

    task automatic frame_tick();
        @(posedge Clk); #1 frame_clk = 1'b1;
        repeat (2) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (12) @(posedge Clk);
    endtask

    task automatic do_reset();
        @(posedge Clk); #1 Reset_n = 1'b0;
        #1 check("reset_outputs", 32'({hit_pulse, miss_pulse, score, combo, busy}), 32'd0);
        @(posedge Clk); #1 Reset_n = 1'b1;
        exp_score = 0;
        exp_combo = 0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge Clk);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy_cnt;
        exp_score = 0;
        exp_combo = 0;

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_state", 32'({hit_pulse, miss_pulse, score, combo, busy}), 32'd0);
        @(posedge Clk); #1 Reset_n = 1'b1;
        repeat (2) @(posedge Clk);

        // Single hit on lane 1 with latency check
        note_y[1]  = 10'd410;
        note_valid = 5'b00010;
        push_resp(5'b00010, 5'b0, 10, 1);
        @(posedge Clk); #1 keycode = 8'h16;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("latency_early", 32'(hit_pulse), 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        check("latency_hit", 32'(hit_pulse), 32'b00010);
        #1 keycode = 8'h00;
        drain("drain_hit");

        // Combo scoring on lane 0 from a fresh score
        do_reset();
        note_y[0]  = 10'd400;
        note_valid = 5'b00001;
        push_resp(5'b00001, 5'b0, 10, 1);
        press(8'h04);
        rearm(0);
        push_resp(5'b00001, 5'b0, 21, 2);
        press(8'h04);
        rearm(0);
        push_resp(5'b00001, 5'b0, 33, 3);
        @(posedge Clk); #1 keycode = 8'h04;
        repeat (4) @(posedge Clk);
        rearm(0);
        repeat (10) @(posedge Clk);
        #1 keycode = 8'h00;
        drain("drain_combo");
        @(negedge Clk);
        check("combo_score", 32'(score), 32'd33);
        check("combo_count", 32'(combo), 32'd3);

        // Pass-through miss on lane 3; lane 4 sits exactly on the late edge
        note_y[3]  = 10'd417;
        note_y[4]  = 10'd416;
        note_valid = 5'b11001;
        push_resp(5'b0, 5'b01000, 33, 0);
        frame_tick();
        drain("drain_passmiss");
        note_y[3] = 10'd430;
        frame_tick();
        drain("drain_norepeat");
        @(negedge Clk);
        check("combo_after_miss", 32'(combo), 32'd0);

        // Bad press just early, boundary hits, non-lane key
        note_y[2]  = 10'd383;
        note_valid = 5'b11101;
        push_resp(5'b0, 5'b00100, 33, 0);
        press(8'h07);
        note_y[2] = 10'd384;
        push_resp(5'b00100, 5'b0, 43, 1);
        press(8'h07);
        press(8'h2C);
        push_resp(5'b10000, 5'b0, 54, 2);
        press(8'h0A);
        drain("drain_edges");

        // Press and frame tick land together: JUDGE then full SCAN
        push_resp(5'b00001, 5'b0, 66, 3);
        @(posedge Clk); #1 frame_clk = 1'b1;
        @(posedge Clk);
        @(posedge Clk); #1 keycode = 8'h04;
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            if (busy) busy_cnt++;
            if (i == 2) frame_clk = 1'b0;
            if (i == 4) keycode = 8'h00;
        end
        check("collision_busy_cycles", 32'(busy_cnt), 32'd6);
        drain("drain_collision");

        // Reset in the middle of a scan that would otherwise miss lane 4
        note_y[4] = 10'd500;
        rearm(4);
        @(posedge Clk); #1 frame_clk = 1'b1;
        repeat (2) @(posedge Clk);
        #1 frame_clk = 1'b0;
        for (int i = 0; i < 20 && !busy; i++) @(negedge Clk);
        check("scan_started", 32'(busy), 32'd1);
        @(posedge Clk); #1 Reset_n = 1'b0;
        #1 check("reset_mid_scan", 32'({hit_pulse, miss_pulse, score, combo, busy}), 32'd0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        exp_score = 0;
        exp_combo = 0;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        check("busy_after_reset", 32'(busy), 32'd0);
        drain("drain_reset");

        // Long hit run to saturate combo and score
        note_valid = 5'b00001;
        note_y[0]  = 10'd400;
        for (int h = 0; h < 145; h++) begin
            push_model_hit(0);
            press(8'h04);
            rearm(0);
        end
        drain("drain_saturation");
        @(negedge Clk);
        check("score_saturated", 32'(score), 32'd9999);
        check("combo_saturated", 32'(combo), 32'd99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
